// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the vector ALU command sequencer.
package alu_seq_pkg;

  localparam int OP_W = 3;
  localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/alu_vec_sequencer.sv
// Single-outstanding sequencer for the N-lane vector ALU; response 2+ALU_LAT cycles after accept.
// rsp_ready low parks the FSM in DONE with frozen outputs and cmd_ready low.
module alu_vec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_ALU   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_op,
  input  logic [N_ALU-1:0]           cmd_mask,
  input  logic [WIDTH*N_ALU-1:0]     cmd_a,
  input  logic [WIDTH*N_ALU-1:0]     cmd_b,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [WIDTH*N_ALU-1:0]     alu_a,
  output logic [WIDTH*N_ALU-1:0]     alu_b,
  output logic [OP_W-1:0]            alu_select,
  output logic [N_ALU-1:0]           alu_enable,
  input  logic [2*WIDTH*N_ALU-1:0]   alu_data_out,
  input  logic [N_ALU-1:0]           alu_carry_out,
  input  logic [N_ALU-1:0]           alu_a_greater,
  input  logic [N_ALU-1:0]           alu_a_equal,
  input  logic [N_ALU-1:0]           alu_a_less,
  input  logic [N_ALU-1:0]           alu_inf,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH*N_ALU-1:0]   rsp_data,
  output logic [N_ALU-1:0]           rsp_carry,
  output logic [N_ALU-1:0]           rsp_gt,
  output logic [N_ALU-1:0]           rsp_eq,
  output logic [N_ALU-1:0]           rsp_lt,
  output logic [N_ALU-1:0]           rsp_inf,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy,
  output logic [15:0]                op_count
);

  localparam int LW    = 2 * WIDTH;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ALU_LAT > 1) ? ALU_LAT - 2 : 0);

  seq_state_t            state;
  seq_state_t            state_d;
  logic [CNT_W-1:0]      wait_cnt;
  logic [N_ALU-1:0]      mask_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  accept;
  logic [LW*N_ALU-1:0]   masked_data;

  assign cmd_ready  = (state == IDLE) || ((state == DONE) && rsp_ready);
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  // Decoded from state so an async reset removes the pulse without a clock edge.
  assign alu_enable = (state == ISSUE) ? mask_q : '0;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = (cmd_mask != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        state_d = (ALU_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wait_cnt == CNT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = DONE;
      end
      DONE: begin
        if (accept) state_d = (cmd_mask != '0) ? ISSUE : DONE;
        else if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    masked_data = '0;
    for (int i = 0; i < N_ALU; i++) begin
      if (mask_q[i]) masked_data[i*LW +: LW] = alu_data_out[i*LW +: LW];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      mask_q     <= '0;
      tag_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      rsp_data   <= '0;
      rsp_carry  <= '0;
      rsp_gt     <= '0;
      rsp_eq     <= '0;
      rsp_lt     <= '0;
      rsp_inf    <= '0;
      rsp_tag    <= '0;
      op_count   <= '0;
    end else begin
      state <= state_d;

      if (accept) begin
        mask_q     <= cmd_mask;
        tag_q      <= cmd_tag;
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_select <= cmd_op;
        // An empty mask never touches the ALU; the response is built here directly.
        if (cmd_mask == '0) begin
          rsp_data  <= '0;
          rsp_carry <= '0;
          rsp_gt    <= '0;
          rsp_eq    <= '0;
          rsp_lt    <= '0;
          rsp_inf   <= '0;
          rsp_tag   <= cmd_tag;
        end
      end

      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (state == CAPTURE) begin
        rsp_data  <= masked_data;
        rsp_carry <= alu_carry_out & mask_q;
        rsp_gt    <= alu_a_greater & mask_q;
        rsp_eq    <= alu_a_equal & mask_q;
        rsp_lt    <= alu_a_less & mask_q;
        rsp_inf   <= alu_inf & mask_q;
        rsp_tag   <= tag_q;
      end

      if (rsp_valid && rsp_ready && (op_count != OP_COUNT_MAX)) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_vec_sequencer.sv
// Bench for alu_vec_sequencer: behavioural ALU, directed scenarios and a randomized scoreboard stream.
module tb_alu_vec_sequencer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LW = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [2:0]    op;
    logic [N-1:0]  mask;
    logic [W*N-1:0] a;
    logic [W*N-1:0] b;
    logic [TW-1:0] tag;
  } cmd_t;

  // flags field: {carry, gt, eq, lt, inf}, each N bits
  typedef struct packed {
    logic [LW*N-1:0] data;
    logic [5*N-1:0]  flags;
    logic [TW-1:0]   tag;
  } rsp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_valid, cmd_ready, rsp_ready, rsp_valid, busy;
  logic [2:0]     cmd_op, alu_select;
  logic [N-1:0]   cmd_mask, alu_enable;
  logic [W*N-1:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [TW-1:0]  cmd_tag, rsp_tag;
  logic [LW*N-1:0] alu_dout, rsp_data;
  logic [N-1:0]   alu_c, alu_g, alu_e, alu_l, alu_i;
  logic [N-1:0]   rsp_carry, rsp_gt, rsp_eq, rsp_lt, rsp_inf;
  logic [15:0]    op_count;
  rsp_t           obs;

  logic           cmd_ready3, rsp_valid3, busy3;
  logic [2:0]     alu_select3;
  logic [N-1:0]   alu_enable3;
  logic [W*N-1:0] alu_a3, alu_b3;
  logic [LW*N-1:0] rsp_data3;
  logic [N-1:0]   rsp_carry3, rsp_gt3, rsp_eq3, rsp_lt3, rsp_inf3;
  logic [TW-1:0]  rsp_tag3;
  logic [15:0]    op_count3;

  int vectors = 0;
  int miscompares = 0;
  int en_cycles = 0;
  int cyc = 0;
  cmd_t exp_q[$];
  int acc_cyc[$];
  int rsp_cyc[$];

  assign obs = {rsp_data, rsp_carry, rsp_gt, rsp_eq, rsp_lt, rsp_inf, rsp_tag};

  alu_vec_sequencer #(.WIDTH(W), .N_ALU(N), .ALU_LAT(1), .TAG_W(TW)) u_dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
    .alu_data_out(alu_dout), .alu_carry_out(alu_c), .alu_a_greater(alu_g),
    .alu_a_equal(alu_e), .alu_a_less(alu_l), .alu_inf(alu_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_inf(rsp_inf),
    .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count)
  );

  alu_vec_sequencer #(.WIDTH(W), .N_ALU(N), .ALU_LAT(3), .TAG_W(TW)) u_dut3 (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_select(alu_select3), .alu_enable(alu_enable3),
    .alu_data_out('0), .alu_carry_out('0), .alu_a_greater('0),
    .alu_a_equal('0), .alu_a_less('0), .alu_inf('0),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
    .rsp_carry(rsp_carry3), .rsp_gt(rsp_gt3), .rsp_eq(rsp_eq3), .rsp_lt(rsp_lt3), .rsp_inf(rsp_inf3),
    .rsp_tag(rsp_tag3), .busy(busy3), .op_count(op_count3)
  );

  function automatic logic [LW-1:0] lane_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    lane_res = {8'h00, a} + {8'h00, b};
      3'd1:    lane_res = {8'h00, a} * {8'h00, b};
      default: lane_res = {8'h00, a ^ b};
    endcase
  endfunction

  // {inf, lt, eq, gt, carry}
  function automatic logic [4:0] lane_flags(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    lane_flags = {(op == 3'd1) && (b == '0), a < b, a == b, a > b, s[W]};
  endfunction

  // Behavioural ALU: each lane registers its result only when its enable is high.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      alu_dout <= '0;
      {alu_i, alu_l, alu_e, alu_g, alu_c} <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alu_enable[i]) begin
          alu_dout[i*LW +: LW] <= lane_res(alu_select, alu_a[i*W +: W], alu_b[i*W +: W]);
          {alu_i[i], alu_l[i], alu_e[i], alu_g[i], alu_c[i]} <= lane_flags(alu_select, alu_a[i*W +: W], alu_b[i*W +: W]);
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_enable != '0) en_cycles++;

  // Reference: masked-off lanes and zero-mask commands report zero data and flags.
  function automatic rsp_t ref_rsp(input cmd_t c);
    logic [4:0] f;
    ref_rsp = '0;
    ref_rsp.tag = c.tag;
    for (int i = 0; i < N; i++) begin
      if (c.mask[i]) begin
        ref_rsp.data[i*LW +: LW] = lane_res(c.op, c.a[i*W +: W], c.b[i*W +: W]);
        f = lane_flags(c.op, c.a[i*W +: W], c.b[i*W +: W]);
        ref_rsp.flags[4*N + i] = f[0];
        ref_rsp.flags[3*N + i] = f[1];
        ref_rsp.flags[2*N + i] = f[2];
        ref_rsp.flags[1*N + i] = f[3];
        ref_rsp.flags[i]       = f[4];
      end
    end
  endfunction

  function automatic cmd_t rand_cmd(input bit nz);
    cmd_t c;
    c.op   = 3'($urandom_range(0, 7));
    c.mask = 4'($urandom);
    if (nz && c.mask == '0) c.mask = 4'hF;
    c.a    = $urandom;
    c.b    = $urandom;
    c.tag  = 4'($urandom);
    return c;
  endfunction

  task automatic apply(input cmd_t c);
    cmd_op = c.op; cmd_mask = c.mask; cmd_a = c.a; cmd_b = c.b; cmd_tag = c.tag;
  endtask

  // Presents c for one cycle from an idle DUT; returns 1ns into cycle T+1.
  task automatic drive_cmd(input cmd_t c);
    @(posedge clk); #1;
    apply(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit rand_gaps);
    cmd_t cur, last;
    rsp_t e;
    bit acc, pending;
    int sent, got, budget;
    sent = 0; got = 0; budget = 0; pending = 1'b1;
    exp_q.delete(); acc_cyc.delete(); rsp_cyc.delete();
    cur = rand_cmd(!rand_gaps);
    last = cur;
    @(posedge clk); #1;
    apply(cur);
    cmd_valid = 1'b1;
    while (got < n && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (alu_enable !== '0) begin
        vectors++;
        if (alu_enable !== last.mask || alu_a !== last.a) begin
          miscompares++;
          $display("FAIL stream_enable: got en=%h a=%h, want en=%h a=%h", alu_enable, alu_a, last.mask, last.a);
        end
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_unexpected_rsp: got tag=%h, want no response", rsp_tag);
        end else begin
          e = ref_rsp(exp_q.pop_front());
          if (obs !== e) begin
            miscompares++;
            $display("FAIL stream_rsp: got %h, want %h", obs, e);
          end
        end
        rsp_cyc.push_back(cyc);
        got++;
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        exp_q.push_back(cur);
        acc_cyc.push_back(cyc);
        last = cur;
        sent++;
      end
      @(posedge clk); #1;
      if (acc) begin
        pending = (sent < n);
        if (pending) cur = rand_cmd(!rand_gaps);
        cmd_valid = 1'b0;
      end
      if (pending && !cmd_valid) cmd_valid = !rand_gaps || ($urandom_range(0, 2) == 0);
      apply(cur);
      if (rand_gaps) rsp_ready = ($urandom_range(0, 3) != 0);
    end
    vectors++;
    if (got != n) begin
      miscompares++;
      $display("FAIL stream_timeout: got %0d responses, want %0d", got, n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, busy, alu_enable} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b en=%h, want 1 0 0 0", cmd_ready, rsp_valid, busy, alu_enable);
    end
    vectors++;
    if ({alu_a, alu_b, alu_select} !== '0) begin
      miscompares++;
      $display("FAIL reset_alu_regs: got a=%h b=%h sel=%h, want 0", alu_a, alu_b, alu_select);
    end
    vectors++;
    if (obs !== '0 || op_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got rsp=%h cnt=%h, want 0", obs, op_count);
    end
    arst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b busy=%b, want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic_add();
    cmd_t c;
    int en0;
    c = '{op: 3'd0, mask: 4'hF, a: 32'h04030201, b: 32'h01010101, tag: 4'd5};
    rsp_ready = 1'b1;
    en0 = en_cycles;
    drive_cmd(c);
    @(negedge clk);
    vectors++;
    if (alu_enable !== 4'hF) begin
      miscompares++;
      $display("FAIL add_enable_t1: got %h, want f", alu_enable);
    end
    @(negedge clk);
    vectors++;
    if ({alu_enable, rsp_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL add_t2: got en=%h vld=%b, want 0 0", alu_enable, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0005_0004_0003_0002 || rsp_tag !== 4'd5) begin
      miscompares++;
      $display("FAIL add_rsp_t3: got vld=%b data=%h tag=%h, want 1 0005000400030002 5", rsp_valid, rsp_data, rsp_tag);
    end
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd1 || (en_cycles - en0) != 1) begin
      miscompares++;
      $display("FAIL add_count: got cnt=%0d pulses=%0d, want 1 1", op_count, en_cycles - en0);
    end
  endtask

  task automatic test_mask_backpressure();
    cmd_t c;
    rsp_t e;
    c = '{op: 3'd0, mask: 4'b0101, a: 32'h04030201, b: 32'h01010101, tag: 4'd9};
    e = ref_rsp(c);
    rsp_ready = 1'b0;
    drive_cmd(c);
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0000_0004_0000_0002) begin
      miscompares++;
      $display("FAIL mask_data: got vld=%b data=%h, want 1 0000000400000002", rsp_valid, rsp_data);
    end
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL mask_flags: got %h, want %h", obs, e);
    end
    // A command offered while stalled must be ignored.
    @(posedge clk); #1;
    apply('{op: 3'd2, mask: 4'hF, a: 32'hDEADBEEF, b: 32'h12345678, tag: 4'hC});
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (!(rsp_valid === 1'b1 && cmd_ready === 1'b0 && obs === e && alu_a === c.a)) begin
        miscompares++;
        $display("FAIL hold_%0d: got vld=%b rdy=%b rsp=%h a=%h, want 1 0 %h %h", k, rsp_valid, cmd_ready, obs, alu_a, e, c.a);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got cnt=%0d busy=%b, want 2 0", op_count, busy);
    end
  endtask

  task automatic test_zero_mask();
    cmd_t c;
    rsp_t e;
    int en0;
    c = rand_cmd(1'b0);
    c.mask = '0;
    e = ref_rsp(c);
    en0 = en_cycles;
    rsp_ready = 1'b1;
    drive_cmd(c);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || obs !== e || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL zero_rsp_t1: got vld=%b rsp=%h, want 1 %h", rsp_valid, obs, e);
    end
    @(negedge clk);
    vectors++;
    if ((en_cycles - en0) != 0 || op_count !== 16'd3 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: got pulses=%0d cnt=%0d vld=%b, want 0 3 0", en_cycles - en0, op_count, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int oc0;
    oc0 = op_count;
    run_stream(2, 1'b0);
    vectors++;
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_counts: got acc=%0d rsp=%0d, want 2 2", acc_cyc.size(), rsp_cyc.size());
    end else begin
      // Second accept coincides with first response, which first shows at T+3.
      if (acc_cyc[1] != rsp_cyc[0] || (acc_cyc[1] - acc_cyc[0]) != 3) begin
        miscompares++;
        $display("FAIL b2b_timing: got acc1=%0d rsp0=%0d gap=%0d, want acc1=rsp0 gap=3", acc_cyc[1], rsp_cyc[0], acc_cyc[1] - acc_cyc[0]);
      end
    end
    @(negedge clk);
    vectors++;
    if (op_count !== 16'(oc0 + 2)) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d, want %0d", op_count, oc0 + 2);
    end
  endtask

  task automatic test_random();
    int oc0;
    oc0 = op_count;
    run_stream(40, 1'b1);
    @(negedge clk);
    vectors++;
    if (op_count !== 16'(oc0 + 40)) begin
      miscompares++;
      $display("FAIL random_count: got %0d, want %0d", op_count, oc0 + 40);
    end
  endtask

  task automatic test_lat3_and_reset();
    cmd_t c;
    logic [4:0] vld_hist, en_hist;
    int seen;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    rsp_ready = 1'b1;
    c = rand_cmd(1'b1);
    c.mask = 4'hF;
    drive_cmd(c);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vld_hist[k] = rsp_valid3;
      en_hist[k] = (alu_enable3 == 4'hF);
    end
    vectors++;
    if (vld_hist !== 5'b10000 || en_hist !== 5'b00001) begin
      miscompares++;
      $display("FAIL lat3_timing: got vld=%b en=%b, want 10000 00001", vld_hist, en_hist);
    end
    // Reset during ISSUE: the pulse must drop with no clock edge.
    drive_cmd(c);
    #2;
    vectors++;
    if (alu_enable !== 4'hF || alu_enable3 !== 4'hF) begin
      miscompares++;
      $display("FAIL issue_pre: got en=%h en3=%h, want f f", alu_enable, alu_enable3);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if ({alu_enable, alu_enable3, busy, busy3} !== '0) begin
      miscompares++;
      $display("FAIL issue_reset: got en=%h en3=%h busy=%b busy3=%b, want 0", alu_enable, alu_enable3, busy, busy3);
    end
    @(negedge clk);
    arst = 1'b0;
    // Reset during WAIT of the three-cycle-latency instance.
    drive_cmd(c);
    @(posedge clk); #1;
    vectors++;
    if (busy3 !== 1'b1 || alu_enable3 !== '0 || rsp_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_pre: got busy3=%b en3=%h vld3=%b, want 1 0 0", busy3, alu_enable3, rsp_valid3);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if ({alu_enable3, busy3, rsp_valid3, cmd_ready3} !== {4'h0, 1'b0, 1'b0, 1'b1} || alu_a3 !== '0) begin
      miscompares++;
      $display("FAIL wait_reset: got en3=%h busy3=%b vld3=%b rdy3=%b a3=%h, want 0 0 0 1 0",
               alu_enable3, busy3, rsp_valid3, cmd_ready3, alu_a3);
    end
    @(negedge clk);
    arst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid3 || rsp_valid || alu_enable3 != '0) seen++;
    end
    vectors++;
    if (seen != 0 || op_count3 !== 16'd0 || busy3 !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_discard: got activity=%0d cnt3=%0d busy3=%b, want 0 0 0", seen, op_count3, busy3);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    apply('0);
    test_reset();
    test_basic_add();
    test_mask_backpressure();
    test_zero_mask();
    test_back_to_back();
    test_random();
    test_lat3_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
